// File: rtl/io_debounce.sv
// -----------------------------------------------------------------------------
// io_debounce
//
// Input conditioner for board switch/button pins. Each of N_CH channels is
// synchronised through a SYNC_STAGES-deep flop chain and then debounced by its
// own stable-time counter. The debounced level is only updated after the
// synchronised value has differed from it for DB_CYCLES consecutive edges.
// Level changes produce a registered one-cycle pulse and set a sticky flag
// (write-1-to-clear). o_irq is the OR of all sticky flags.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   i_raw         asynchronous raw pin levels          [N_CH]
//   i_clr_wen     strobe enabling the sticky-flag clear
//   i_clr_mask    write-1-to-clear mask for o_rise/o_fall [N_CH]
//   o_level       debounced level                      [N_CH]
//   o_pulse_rise  one-cycle pulse on level 0->1        [N_CH]
//   o_pulse_fall  one-cycle pulse on level 1->0        [N_CH]
//   o_rise        sticky rise flag                     [N_CH]
//   o_fall        sticky fall flag                     [N_CH]
//   o_irq         OR of every sticky flag
// -----------------------------------------------------------------------------
module io_debounce #(
    parameter  int N_CH        = 32,
    parameter  int SYNC_STAGES = 2,
    parameter  int DB_CYCLES   = 16,
    localparam int CNT_W       = $clog2(DB_CYCLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_raw,
    input  logic            i_clr_wen,
    input  logic [N_CH-1:0] i_clr_mask,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_pulse_rise,
    output logic [N_CH-1:0] o_pulse_fall,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic            o_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Synchroniser chain: index 0 samples the pin, index SYNC_STAGES-1 is used.
    logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
    logic [N_CH-1:0][CNT_W-1:0]       r_cnt;
    logic [N_CH-1:0]                  r_level;
    logic [N_CH-1:0]                  r_pulse_rise;
    logic [N_CH-1:0]                  r_pulse_fall;
    logic [N_CH-1:0]                  r_rise;
    logic [N_CH-1:0]                  r_fall;

    logic [N_CH-1:0]                  w_s;
    logic [N_CH-1:0][CNT_W-1:0]       w_cnt_nxt;
    logic [N_CH-1:0]                  w_accept;
    logic [N_CH-1:0]                  w_set_rise;
    logic [N_CH-1:0]                  w_set_fall;
    logic [N_CH-1:0]                  w_clr;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Shift the raw pins through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Per-channel stable-time counter; a channel is accepted on the edge where
    // it has already differed for DB_CYCLES-1 edges, so cnt never wraps.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_accept  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_s[i] == r_level[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_cnt_nxt[i] = '0;
                w_accept[i]  = 1'b1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // An accepted channel moves to the synchronised value, so its direction
    // is given by that value.
    assign w_set_rise = w_accept & w_s;
    assign w_set_fall = w_accept & ~w_s;
    assign w_clr      = i_clr_wen ? i_clr_mask : {N_CH{1'b0}};

    // Debounced level, pulses and sticky flags; a set in the same cycle as a
    // clear wins because the set term is ORed in after masking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_level      <= '0;
            r_pulse_rise <= '0;
            r_pulse_fall <= '0;
            r_rise       <= '0;
            r_fall       <= '0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_level      <= r_level ^ w_accept;
            r_pulse_rise <= w_set_rise;
            r_pulse_fall <= w_set_fall;
            r_rise       <= (r_rise & ~w_clr) | w_set_rise;
            r_fall       <= (r_fall & ~w_clr) | w_set_fall;
        end
    end

    assign o_level      = r_level;
    assign o_pulse_rise = r_pulse_rise;
    assign o_pulse_fall = r_pulse_fall;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_irq        = |{r_rise, r_fall};

endmodule

// File: tb/tb_io_debounce.sv
module tb_io_debounce;

    localparam int N  = 32;
    localparam int SS = 2;
    localparam int DB = 16;

    typedef struct {
        logic [N-1:0] level;
        logic [N-1:0] pr;
        logic [N-1:0] pf;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         irq;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] i_raw = '0;
    logic         i_clr_wen = 1'b0;
    logic [N-1:0] i_clr_mask = '0;
    logic [N-1:0] o_level, o_pulse_rise, o_pulse_fall, o_rise, o_fall;
    logic         o_irq;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb[$];

    // reference model state
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_rise  = '0;
    logic [N-1:0] m_fall  = '0;
    logic [N-1:0] hist[$];
    int           run[N];

    io_debounce #(.N_CH(N), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_raw        (i_raw),
        .i_clr_wen    (i_clr_wen),
        .i_clr_mask   (i_clr_mask),
        .o_level      (o_level),
        .o_pulse_rise (o_pulse_rise),
        .o_pulse_fall (o_pulse_fall),
        .o_rise       (o_rise),
        .o_fall       (o_fall),
        .o_irq        (o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle (called at a negedge), predict the outcome of the next
    // posedge with the model, queue it, and return at the following negedge.
    task automatic step(input logic [N-1:0] raw, input logic wen,
                        input logic [N-1:0] mask, input logic r);
        exp_t         e;
        logic [N-1:0] s, set_r, set_f, clr;
        i_raw = raw; i_clr_wen = wen; i_clr_mask = mask; rst = r;
        set_r = '0; set_f = '0;
        if (r) begin
            m_level = '0; m_rise = '0; m_fall = '0;
            hist.delete();
            for (int k = 0; k < SS; k++) hist.push_back('0);
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            // value seen by the debouncer = raw applied SS edges earlier
            s = hist.pop_front();
            hist.push_back(raw);
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_level[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        m_level[i] = s[i];
                        run[i] = 0;
                        if (s[i]) set_r[i] = 1'b1;
                        else      set_f[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            clr = wen ? mask : '0;
            m_rise = (m_rise & ~clr) | set_r;
            m_fall = (m_fall & ~clr) | set_f;
        end
        e.level = m_level; e.pr = set_r; e.pf = set_f;
        e.rise = m_rise; e.fall = m_fall; e.irq = |{m_rise, m_fall};
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input logic [N-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0, '0, 1'b0);
    endtask

    // Monitor: compare every settled output set against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_level", 64'(o_level), 64'(e.level));
                chk("sb_pulse_rise", 64'(o_pulse_rise), 64'(e.pr));
                chk("sb_pulse_fall", 64'(o_pulse_fall), 64'(e.pf));
                chk("sb_rise", 64'(o_rise), 64'(e.rise));
                chk("sb_fall", 64'(o_fall), 64'(e.fall));
                chk("sb_irq", 64'(o_irq), 64'(e.irq));
            end
        end
    end

    initial begin
        logic [N-1:0] raw;
        logic [N-1:0] ch3;
        ch3 = '0; ch3[3] = 1'b1;
        @(negedge clk);
        repeat (3) step('0, 1'b0, '0, 1'b1);
        chk("reset_level", 64'(o_level), 64'd0);
        chk("reset_irq", 64'(o_irq), 64'd0);
        hold('0, 50);
        chk("idle_level", 64'(o_level), 64'd0);
        chk("idle_flags", 64'({o_rise, o_fall}), 64'd0);
        chk("idle_irq", 64'(o_irq), 64'd0);

        // clean rise on channel 3, clear collides with the set edge
        hold(ch3, 17);
        chk("rise3_edge17_level", 64'(o_level[3]), 64'd0);
        step(ch3, 1'b1, ch3, 1'b0);
        chk("rise3_edge18_level", 64'(o_level), 64'(ch3));
        chk("rise3_pulse", 64'(o_pulse_rise), 64'(ch3));
        chk("rise3_set_beats_clear", 64'(o_rise), 64'(ch3));
        chk("rise3_irq", 64'(o_irq), 64'd1);
        step(ch3, 1'b1, ch3, 1'b0);
        chk("rise3_pulse_one_cycle", 64'(o_pulse_rise[3]), 64'd0);
        chk("rise3_cleared", 64'(o_rise[3]), 64'd0);
        chk("irq_after_clear", 64'(o_irq), 64'd0);
        step(ch3, 1'b0, ch3, 1'b0);

        // bounce on channel 0: 15 cycles rejected, 16 cycles accepted
        hold(ch3 | 32'h1, 15);
        hold(ch3, 20);
        chk("bounce15_level0", 64'(o_level[0]), 64'd0);
        chk("bounce15_rise0", 64'(o_rise[0]), 64'd0);
        hold(ch3 | 32'h1, 16);
        hold(ch3, 2);
        chk("bounce16_level0", 64'(o_level[0]), 64'd1);
        chk("bounce16_rise0", 64'(o_rise[0]), 64'd1);
        hold(ch3, 20);
        step(ch3, 1'b1, '1, 1'b0);
        chk("clear_all_irq", 64'(o_irq), 64'd0);

        // clean fall on channel 3
        hold('0, 17);
        chk("fall3_edge17_level", 64'(o_level[3]), 64'd1);
        hold('0, 1);
        chk("fall3_edge18_level", 64'(o_level[3]), 64'd0);
        chk("fall3_pulse", 64'(o_pulse_fall), 64'(ch3));
        chk("fall3_flag", 64'(o_fall), 64'(ch3));
        chk("fall3_rise_untouched", 64'(o_rise[3]), 64'd0);
        hold('0, 1);
        chk("fall3_pulse_one_cycle", 64'(o_pulse_fall[3]), 64'd0);

        // reset in the middle of a debounce on channel 5
        raw = '0; raw[5] = 1'b1;
        hold(raw, 12);
        step(raw, 1'b1, '0, 1'b1);
        chk("midrst_outputs", 64'({o_level, o_rise, o_fall}), 64'd0);
        chk("midrst_irq", 64'(o_irq), 64'd0);
        hold(raw, 17);
        chk("midrst_edge17_level", 64'(o_level[5]), 64'd0);
        hold(raw, 1);
        chk("midrst_edge18_level", 64'(o_level[5]), 64'd1);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            logic         wen, r;
            logic [N-1:0] m;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) raw[i] = ~raw[i];
            wen = ($urandom_range(0, 7) == 0);
            m   = $urandom;
            r   = ($urandom_range(0, 799) == 0);
            step(raw, wen, m, r);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_debounce.md
Name: io_debounce

Overview:
- Parametrised input conditioner for the board switch/button inputs (io_sw, io_btn) of the single-cycle core.
- Synchronises asynchronous pins, debounces each channel with its own stable-time counter, and exposes clean levels.
- Provides one-cycle edge pulses, plus sticky rise/fall flags with write-1-to-clear and a summary interrupt for the LSU input-peripheral region.
- Generalises the fixed 32-bit raw switch/button pass-through to N channels with configurable sync depth and debounce time.

Parameters:
N_CH, 32, number of independent input channels
SYNC_STAGES, 2, flip-flops in each synchroniser chain (legal: >= 2)
DB_CYCLES, 16, consecutive clock cycles a new value must persist before it is accepted (legal: >= 2)
CNT_W, $clog2(DB_CYCLES), width of each per-channel debounce counter (derived; do not override)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, synchronous, active-high
i_raw  input  N_CH  asynchronous raw pin levels
i_clr_wen  input  1  strobe: clear sticky flags selected by i_clr_mask this cycle
i_clr_mask  input  N_CH  write-1-to-clear mask applied to both o_rise and o_fall
o_level  output  N_CH  debounced level per channel
o_pulse_rise  output  N_CH  one-cycle pulse when o_level goes 0->1
o_pulse_fall  output  N_CH  one-cycle pulse when o_level goes 1->0
o_rise  output  N_CH  sticky rise flag per channel
o_fall  output  N_CH  sticky fall flag per channel
o_irq  output  1  OR-reduction of all o_rise and o_fall bits

Behaviour:
- Reset (clk edge with rst=1):
  - All sync flops, counters, o_level, o_pulse_*, o_rise and o_fall go to 0.
  - o_irq therefore reads 0.
  - Reset mid-debounce discards any partial count.
  - Reset dominates i_clr_wen.
- Synchroniser: per channel, a SYNC_STAGES-deep shift register clocked by clk. Let s = last stage.
- Per-channel debounce, evaluated every rising edge when rst=0:
  - If s == o_level: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: o_level <= s; cnt <= 0; fire the matching pulse and set the matching sticky flag.
  - Else: cnt <= cnt+1.
- Latency:
  - Count the first edge that samples a new, clean raw value as edge 1.
  - o_level changes after edge SYNC_STAGES+DB_CYCLES (18 at defaults).
- Glitch rejection:
  - Any return of s to o_level before the count completes resets cnt to 0.
  - A pulse of s shorter than DB_CYCLES cycles never changes o_level.
  - A pulse of exactly DB_CYCLES cycles is accepted.
- Counter wrap: cnt never exceeds DB_CYCLES-1; no arithmetic wrap occurs.
- Pulses:
  - o_pulse_rise/o_pulse_fall are registered.
  - Each is high for exactly the one cycle following the edge on which o_level changes.
  - Otherwise 0; never both high on one channel.
- Sticky flags:
  - Set by the same event that fires the pulse.
  - Cleared when i_clr_wen=1 and the corresponding i_clr_mask bit=1.
  - Simultaneous set and clear on one bit: set wins (flag stays 1).
  - Clear with i_clr_wen=0 has no effect.
  - Clearing one channel leaves all others unchanged.
- o_irq: combinational from the registered sticky flags; no extra latency.
- Channels are fully independent; simultaneous transitions on multiple channels are handled in parallel.

Test Plan:
- Reset then hold i_raw=0 for 50 cycles -> o_level=0, all pulses/flags 0, o_irq=0.
- Defaults: i_raw[3] 0->1 clean step -> o_level[3]=1 after edge 18; o_pulse_rise[3]=1 for exactly one cycle; o_rise[3]=1; o_irq=1; other channels unchanged.
- Bounce on channel 0:
  - 0->1 for 15 cycles, back to 0 -> o_level[0] stays 0, no flags.
  - 0->1 for exactly 16 cycles -> o_level[0]=1, o_rise[0]=1.
- Assert i_clr_wen=1 with i_clr_mask=0x8 on the same edge o_rise[3] is being set -> o_rise[3] remains 1; repeat clear a cycle later -> o_rise[3]=0, o_irq=0 if no other flags.
- i_raw[3] 1->0 with o_level[3]=1 -> after edge 18: o_pulse_fall[3] one cycle, o_fall[3]=1, o_rise[3] untouched.
- Assert rst at count 10 of an in-progress debounce -> all outputs 0 next cycle; a subsequent clean step needs the full 18 edges.
